pipe_stage_hs: RTL and testbench

- Parametrised inter-stage pipeline register for the five-stage MIPS core. Replaces the fixed-field enable/clear stage registers with one generic block.
- Carries a packed payload of width DATA_W with a valid/ready handshake, synchronous flush, and an optional 2-entry skid buffer that registers the backward ready path.
- Includes a saturating stall-cycle counter for performance inspection.
- Instantiated between F/D, D/E, E/M and M/W. Stage control drives flush; downstream hazard logic drives out_ready.

---
 rtl/pipe_stage_hs.sv | 63 ++++++
 tb/tb_pipe_stage_hs.sv | 94 +++++++++
 2 files changed

// File: rtl/pipe_stage_hs.sv
// pipe_stage_hs: valid/ready pipeline register with flush, optional 2-entry skid buffer (registered in_ready), saturating stall counter and occupancy
module pipe_stage_hs #(
  parameter int DATA_W = 32,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0,
  parameter int SKID = 1,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [1:0]        occupancy
);
  logic              r_main_v, r_skid_v, r_in_ready;
  logic [DATA_W-1:0] r_main_d, r_skid_d;
  logic [CNT_W-1:0]  r_stall;
  logic [1:0]        r_occ;
  logic              w_acc, w_con, w_move, w_to_main, w_to_skid, w_main_v, w_skid_v;
  logic [DATA_W-1:0] w_main_d, w_skid_d;
  assign in_ready  = (SKID != 0) ? r_in_ready : (out_ready || !r_main_v);
  assign out_valid = r_main_v;
  assign out_data  = r_main_d;
  assign stall_cnt = r_stall;
  assign occupancy = r_occ;
  assign w_acc     = in_valid && in_ready;
  assign w_con     = r_main_v && out_ready;
  assign w_move    = r_skid_v && w_con;
  assign w_to_main = w_acc && (!r_main_v || w_con);
  assign w_to_skid = w_acc && r_main_v && !w_con;
  assign w_main_v  = w_move || w_acc || (r_main_v && !w_con);
  assign w_skid_v  = w_to_skid || (r_skid_v && !w_con);
  assign w_main_d  = w_move ? r_skid_d : w_to_main ? in_data : r_main_d;
  assign w_skid_d  = w_to_skid ? in_data : r_skid_d;
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_main_v   <= 1'b0;
      r_skid_v   <= 1'b0;
      r_main_d   <= CLEAR_VAL;
      r_skid_d   <= CLEAR_VAL;
      r_in_ready <= 1'b1;
      r_occ      <= 2'd0;
    end else begin
      r_main_v   <= w_main_v;
      r_skid_v   <= w_skid_v;
      r_main_d   <= w_main_d;
      r_skid_d   <= w_skid_d;
      r_in_ready <= !w_skid_v;
      r_occ      <= {1'b0, w_main_v} + {1'b0, w_skid_v};
    end
  end
  always_ff @(posedge clk) begin
    if (reset)
      r_stall <= '0;
    else if (r_main_v && !out_ready && !(&r_stall))
      r_stall <= r_stall + CNT_W'(1);
  end
endmodule

// File: tb/tb_pipe_stage_hs.sv
// tb_pipe_stage_hs: directed checks of skid, no-skid and narrow-counter configurations
module tb_pipe_stage_hs;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  int total = 0, bad = 0;
  logic a_fl = 0, a_iv = 0, a_or = 1, a_ir, a_ov;
  logic [31:0] a_id = '0, a_od;
  logic [15:0] a_sc;
  logic [1:0] a_oc;
  logic b_fl = 0, b_iv = 0, b_or = 1, b_ir, b_ov;
  logic [31:0] b_id = '0, b_od;
  logic [15:0] b_sc;
  logic [1:0] b_oc;
  logic c_fl = 0, c_iv = 0, c_or = 1, c_ir, c_ov;
  logic [31:0] c_id = '0, c_od;
  logic [3:0] c_sc;
  logic [1:0] c_oc;
  pipe_stage_hs #(.DATA_W(32), .CLEAR_VAL(32'hDEAD_0000), .SKID(1), .CNT_W(16)) u_a (
    .clk(clk), .reset(reset), .flush(a_fl), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
    .out_valid(a_ov), .out_ready(a_or), .out_data(a_od), .stall_cnt(a_sc), .occupancy(a_oc));
  pipe_stage_hs #(.DATA_W(32), .CLEAR_VAL(32'h0), .SKID(0), .CNT_W(16)) u_b (
    .clk(clk), .reset(reset), .flush(b_fl), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
    .out_valid(b_ov), .out_ready(b_or), .out_data(b_od), .stall_cnt(b_sc), .occupancy(b_oc));
  pipe_stage_hs #(.DATA_W(32), .CLEAR_VAL(32'h0), .SKID(1), .CNT_W(4)) u_c (
    .clk(clk), .reset(reset), .flush(c_fl), .in_valid(c_iv), .in_ready(c_ir), .in_data(c_id),
    .out_valid(c_ov), .out_ready(c_or), .out_data(c_od), .stall_cnt(c_sc), .occupancy(c_oc));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_a(input string tag, input logic v, input logic [31:0] d, input logic [1:0] oc, input logic ir, input logic [15:0] sc);
    chk({tag, ".valid"}, 64'(a_ov), 64'(v));
    chk({tag, ".data"}, 64'(a_od), 64'(d));
    chk({tag, ".occ"}, 64'(a_oc), 64'(oc));
    chk({tag, ".in_ready"}, 64'(a_ir), 64'(ir));
    chk({tag, ".stall"}, 64'(a_sc), 64'(sc));
  endtask
  initial begin
    step();
    chk_a("a_reset", 0, 32'hDEAD_0000, 0, 1, 0);
    chk("b_reset_valid", 64'(b_ov), 0);
    chk("c_reset_stall", 64'(c_sc), 0);
    reset = 0;
    a_iv = 1; a_id = 32'h11; step(); chk_a("stream11", 1, 32'h11, 1, 1, 0);
    a_id = 32'h22; step(); chk_a("stream22", 1, 32'h22, 1, 1, 0);
    a_id = 32'h33; step(); chk_a("stream33", 1, 32'h33, 1, 1, 0);
    a_iv = 0; step(); chk_a("drain", 0, 32'h33, 0, 1, 0);
    a_or = 0; a_iv = 1; a_id = 32'hA1; step(); chk_a("holdA1", 1, 32'hA1, 1, 1, 0);
    a_id = 32'hA2; step(); chk_a("skidA2", 1, 32'hA1, 2, 0, 1);
    a_id = 32'hA3; step(); chk_a("fullA3held", 1, 32'hA1, 2, 0, 2);
    step(); chk_a("fullA3held2", 1, 32'hA1, 2, 0, 3);
    a_or = 1; step(); chk_a("releaseA2", 1, 32'hA2, 1, 1, 3);
    step(); chk_a("releaseA3", 1, 32'hA3, 1, 1, 3);
    a_iv = 0; step(); chk_a("releaseEmpty", 0, 32'hA3, 0, 1, 3);
    a_or = 0; a_iv = 1; a_id = 32'hB1; step(); chk_a("fillB1", 1, 32'hB1, 1, 1, 3);
    a_id = 32'hB2; step(); chk_a("fillB2", 1, 32'hB1, 2, 0, 4);
    a_id = 32'hB3; a_fl = 1; step(); chk_a("flushFull", 0, 32'hDEAD_0000, 0, 1, 5);
    a_fl = 0; a_iv = 0; a_or = 1; step(); chk_a("flushNoB3", 0, 32'hDEAD_0000, 0, 1, 5);
    a_iv = 1; a_id = 32'hB4; a_fl = 1; step(); chk_a("flushDropB4", 0, 32'hDEAD_0000, 0, 1, 5);
    a_fl = 0; a_iv = 0; step(); chk_a("flushAfter", 0, 32'hDEAD_0000, 0, 1, 5);
    b_iv = 1; b_id = 32'hC1; step();
    chk("b_C1_valid", 64'(b_ov), 1); chk("b_C1_data", 64'(b_od), 64'h C1); chk("b_C1_occ", 64'(b_oc), 1);
    b_or = 0; b_id = 32'hC9; #1;
    chk("b_comb_not_ready", 64'(b_ir), 0);
    step();
    chk("b_hold_data", 64'(b_od), 64'hC1); chk("b_hold_stall", 64'(b_sc), 1);
    b_or = 1; b_id = 32'hC2; #1;
    chk("b_comb_ready", 64'(b_ir), 1);
    step();
    chk("b_C2_data", 64'(b_od), 64'hC2); chk("b_C2_valid", 64'(b_ov), 1);
    b_iv = 0; step();
    chk("b_drain_valid", 64'(b_ov), 0); chk("b_drain_data", 64'(b_od), 64'hC2); chk("b_drain_occ", 64'(b_oc), 0);
    c_or = 0; c_iv = 1; c_id = 32'hD0; step(); c_iv = 0;
    chk("c_load_stall", 64'(c_sc), 0);
    for (int i = 0; i < 10; i++) step();
    chk("c_stall10", 64'(c_sc), 10);
    for (int i = 0; i < 10; i++) step();
    chk("c_stall_sat", 64'(c_sc), 15);
    c_or = 1; c_iv = 1; c_id = 32'hD1; reset = 1; step();
    chk("c_rst_valid", 64'(c_ov), 0); chk("c_rst_data", 64'(c_od), 0); chk("c_rst_occ", 64'(c_oc), 0);
    chk("c_rst_ready", 64'(c_ir), 1); chk("c_rst_stall", 64'(c_sc), 0);
    reset = 0; c_iv = 0; step();
    chk("c_noD1", 64'(c_ov), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
